lc_port_arbiter: RTL and testbench

Shares the single lower-cache (LC) port among NUM_REQ upper-level caches (L1D on port 0, L1I on port 1 by default). It accepts line reads and writebacks, serialises them onto the LC request channel, and tracks outstanding reads. LC read responses are routed back to the requester that issued them, matched by line address. It sits between the L1 caches and the LC, and every L1 LC-side handshake passes through it.

---
 rtl/lc_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 69 ++++++
 rtl/lc_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_lc_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_arb_pkg.sv
// Shared types and constants for the lower-cache port arbiter.
package lc_arb_pkg;

   localparam int unsigned NUM_REQ     = 2;
   localparam int unsigned PADDR_BITS  = 22;
   localparam int unsigned B           = 64;
   localparam int unsigned OFF         = $clog2(B);
   localparam int unsigned LINE_BITS   = PADDR_BITS - OFF;
   localparam int unsigned VALUE_BITS  = 8 * B;
   localparam int unsigned OUTSTANDING = 4;
   localparam int unsigned OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TRK_W       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   typedef struct packed {
      logic [PADDR_BITS-1:0] addr;
      logic [VALUE_BITS-1:0] value;
      logic                  we;
   } lc_req_t;

   typedef struct packed {
      logic                 valid;
      logic [LINE_BITS-1:0] line;
      logic [OWN_W-1:0]     owner;
   } lc_trk_entry_t;

   typedef enum logic {
      REQ_EMPTY = 1'b0,
      REQ_FULL  = 1'b1
   } req_state_t;

   // Line address (offset bits stripped) of a physical address
   function automatic logic [LINE_BITS-1:0] line_of(input logic [PADDR_BITS-1:0] addr);
      return addr[PADDR_BITS-1:OFF];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector for the LC request port.
// LC_ARB_FIXED_PRIO_EN: lowest eligible index always wins, no pointer state.
// Otherwise round-robin; pointer moves to winner+1 on each advance strobe.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
`ifndef LC_ARB_FIXED_PRIO_EN
   input  logic               clk_i,
   input  logic               rst_i,
`endif
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] grant_o
);

`ifdef LC_ARB_FIXED_PRIO_EN

   logic unused_advance;
   assign unused_advance = advance_i;

   // Lowest eligible requester wins
   always_comb begin
      logic found;
      found   = 1'b0;
      grant_o = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!found && eligible_i[i]) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

`else

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] win;
   logic             found;

   function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] p, input int unsigned k);
      return IDX_W'((32'(p) + k) % NUM_REQ);
   endfunction

   // First eligible requester at or after the pointer
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      win     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && eligible_i[rot(ptr_q, k)]) begin
            grant_o[rot(ptr_q, k)] = 1'b1;
            win                    = rot(ptr_q, k);
            found                  = 1'b1;
         end
      end
      ptr_d = (advance_i && found) ? rot(win, 1) : ptr_q;
   end

   // Pointer register
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

`endif

endmodule

// File: rtl/lc_port_arbiter.sv
// Shares one lower-cache port among NUM_REQ L1 caches: serialises reads and
// writebacks, tracks outstanding reads by line and routes read responses back.
// Build option LC_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module lc_port_arbiter
   import lc_arb_pkg::*;
(
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic [NUM_REQ-1:0]                   req_valid_in,
   output logic [NUM_REQ-1:0]                   req_ready_out,
   input  logic [NUM_REQ-1:0][PADDR_BITS-1:0]   req_addr_in,
   input  logic [NUM_REQ-1:0][VALUE_BITS-1:0]   req_value_in,
   input  logic [NUM_REQ-1:0]                   req_we_in,
   output logic [NUM_REQ-1:0]                   resp_valid_out,
   input  logic [NUM_REQ-1:0]                   resp_ready_in,
   output logic [PADDR_BITS-1:0]                resp_addr_out,
   output logic [VALUE_BITS-1:0]                resp_value_out,
   output logic                                 lc_valid_out,
   input  logic                                 lc_ready_in,
   output logic [PADDR_BITS-1:0]                lc_addr_out,
   output logic [VALUE_BITS-1:0]                lc_value_out,
   output logic                                 lc_we_out,
   input  logic                                 lc_valid_in,
   output logic                                 lc_ready_out,
   input  logic [PADDR_BITS-1:0]                lc_addr_in,
   input  logic [VALUE_BITS-1:0]                lc_value_in,
   output logic                                 err_out
);

   localparam logic [PADDR_BITS-1:0] OFF_MASK = PADDR_BITS'(B - 1);

   lc_trk_entry_t        trk_q [OUTSTANDING];
   lc_trk_entry_t        trk_d [OUTSTANDING];
   logic                 free_any;
   logic [TRK_W-1:0]     free_idx;
   logic [NUM_REQ-1:0]   same_line;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;
   logic [OWN_W-1:0]     win_idx;
   logic                 can_accept;
   logic                 accept;
   req_state_t           req_state_q, req_state_d;
   lc_req_t              req_q;

   logic                 resp_full_q;
   logic [OWN_W-1:0]     resp_owner_q;
   logic [PADDR_BITS-1:0] resp_addr_q;
   logic [VALUE_BITS-1:0] resp_value_q;
   logic                 resp_drain;
   logic                 lc_resp_hs;
   logic                 cam_hit;
   logic [TRK_W-1:0]     cam_idx;
   logic                 err_q;
   logic                 rst_blank_q;

   // Lowest free tracking entry
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int e = int'(OUTSTANDING) - 1; e >= 0; e--) begin
         if (!trk_q[e].valid) begin
            free_any = 1'b1;
            free_idx = TRK_W'(e);
         end
      end
   end

   // Eligibility: writes always; reads need a free entry and no same-line entry
   always_comb begin
      same_line = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         for (int e = 0; e < int'(OUTSTANDING); e++) begin
            if (trk_q[e].valid && (trk_q[e].line == line_of(req_addr_in[i])))
               same_line[i] = 1'b1;
         end
      end
      eligible = req_valid_in & (req_we_in | ({NUM_REQ{free_any}} & ~same_line));
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
`ifndef LC_ARB_FIXED_PRIO_EN
      .clk_i      (clk_in),
      .rst_i      (rst_in),
`endif
      .eligible_i (eligible),
      .advance_i  (accept),
      .grant_o    (grant)
   );

   // Binary index of the granted requester
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant[i]) win_idx = OWN_W'(i);
      end
   end

   // Request-stage state register
   always_ff @(posedge clk_in) begin
      if (rst_in) req_state_q <= REQ_EMPTY;
      else        req_state_q <= req_state_d;
   end

   // Request-stage next state
   always_comb begin
      req_state_d = req_state_q;
      case (req_state_q)
         REQ_EMPTY: if (accept) req_state_d = REQ_FULL;
         REQ_FULL:  if (lc_ready_in && !accept) req_state_d = REQ_EMPTY;
         default:   req_state_d = REQ_EMPTY;
      endcase
   end

   // Request-stage outputs; nothing is accepted in the quiet cycle after reset
   always_comb begin
      lc_valid_out = 1'b0;
      can_accept   = 1'b0;
      case (req_state_q)
         REQ_EMPTY: can_accept = !rst_blank_q;
         REQ_FULL: begin
            lc_valid_out = 1'b1;
            can_accept   = lc_ready_in && !rst_blank_q;
         end
         default: ;
      endcase
      req_ready_out = grant & {NUM_REQ{can_accept}};
      accept        = |req_ready_out;
   end

   // Request payload; offset is zeroed on capture
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         req_q <= '0;
      end else if (accept) begin
         req_q.addr  <= req_addr_in[win_idx] & ~OFF_MASK;
         req_q.value <= req_value_in[win_idx];
         req_q.we    <= req_we_in[win_idx];
      end
   end

   assign lc_addr_out  = req_q.addr;
   assign lc_value_out = req_q.value;
   assign lc_we_out    = req_q.we;

   // Response register counts as empty in the cycle it drains
   assign resp_drain   = resp_full_q && resp_ready_in[resp_owner_q];
   assign lc_ready_out = (!resp_full_q || resp_drain) && !rst_blank_q;
   assign lc_resp_hs   = lc_valid_in && lc_ready_out;

   // Line-address CAM over valid entries
   always_comb begin
      cam_hit = 1'b0;
      cam_idx = '0;
      for (int e = int'(OUTSTANDING) - 1; e >= 0; e--) begin
         if (trk_q[e].valid && (trk_q[e].line == line_of(lc_addr_in))) begin
            cam_hit = 1'b1;
            cam_idx = TRK_W'(e);
         end
      end
   end

   // Table update: free on response hit, allocate on accepted read
   always_comb begin
      trk_d = trk_q;
      if (lc_resp_hs && cam_hit) trk_d[cam_idx].valid = 1'b0;
      if (accept && !req_we_in[win_idx]) begin
         trk_d[free_idx].valid = 1'b1;
         trk_d[free_idx].line  = line_of(req_addr_in[win_idx]);
         trk_d[free_idx].owner = win_idx;
      end
   end

   // Tracking table register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int e = 0; e < int'(OUTSTANDING); e++) trk_q[e] <= '0;
      end else begin
         trk_q <= trk_d;
      end
   end

   // Response register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         resp_full_q  <= 1'b0;
         resp_owner_q <= '0;
         resp_addr_q  <= '0;
         resp_value_q <= '0;
      end else if (lc_resp_hs && cam_hit) begin
         resp_full_q  <= 1'b1;
         resp_owner_q <= trk_q[cam_idx].owner;
         resp_addr_q  <= lc_addr_in;
         resp_value_q <= lc_value_in;
      end else if (resp_drain) begin
         resp_full_q  <= 1'b0;
      end
   end

   // Sticky unmatched-response flag and post-reset quiet cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         err_q       <= 1'b0;
         rst_blank_q <= 1'b1;
      end else begin
         rst_blank_q <= 1'b0;
         if (lc_resp_hs && !cam_hit) err_q <= 1'b1;
      end
   end

   // One-hot response valid to the owner
   always_comb begin
      resp_valid_out = '0;
      if (resp_full_q) resp_valid_out[resp_owner_q] = 1'b1;
   end

   assign resp_addr_out  = resp_addr_q;
   assign resp_value_out = resp_value_q;
   assign err_out        = err_q;

endmodule

// File: tb/tb_lc_port_arbiter.sv
// Randomised bench for lc_port_arbiter against a transaction-level model.
// Honours LC_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_lc_port_arbiter;
   import lc_arb_pkg::*;

   logic                               clk_in;
   logic                               rst_in;
   logic [NUM_REQ-1:0]                 req_valid_in;
   logic [NUM_REQ-1:0]                 req_ready_out;
   logic [NUM_REQ-1:0][PADDR_BITS-1:0] req_addr_in;
   logic [NUM_REQ-1:0][VALUE_BITS-1:0] req_value_in;
   logic [NUM_REQ-1:0]                 req_we_in;
   logic [NUM_REQ-1:0]                 resp_valid_out;
   logic [NUM_REQ-1:0]                 resp_ready_in;
   logic [PADDR_BITS-1:0]              resp_addr_out;
   logic [VALUE_BITS-1:0]              resp_value_out;
   logic                               lc_valid_out;
   logic                               lc_ready_in;
   logic [PADDR_BITS-1:0]              lc_addr_out;
   logic [VALUE_BITS-1:0]              lc_value_out;
   logic                               lc_we_out;
   logic                               lc_valid_in;
   logic                               lc_ready_out;
   logic [PADDR_BITS-1:0]              lc_addr_in;
   logic [VALUE_BITS-1:0]              lc_value_in;
   logic                               err_out;

   lc_port_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_addr_in(req_addr_in), .req_value_in(req_value_in), .req_we_in(req_we_in),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
      .resp_addr_out(resp_addr_out), .resp_value_out(resp_value_out),
      .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
      .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
      .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out),
      .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
      .err_out(err_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [VALUE_BITS-1:0] obs,
                      input logic [VALUE_BITS-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state: outstanding reads as a list of {line, owner}
   typedef struct {
      logic [LINE_BITS-1:0] line;
      int                   owner;
   } trk_t;

   bit                    m_known = 0;
   bit                    m_blank = 0;
   int                    m_ptr = 0;
   bit                    m_rq_full = 0;
   logic [PADDR_BITS-1:0] m_rq_addr = '0;
   logic [VALUE_BITS-1:0] m_rq_val = '0;
   bit                    m_rq_we = 0;
   trk_t                  m_trk[$];
   bit                    m_rs_full = 0;
   int                    m_rs_owner = 0;
   logic [PADDR_BITS-1:0] m_rs_addr = '0;
   logic [VALUE_BITS-1:0] m_rs_val = '0;
   bit                    m_err = 0;

   // Lower-cache side: read addresses issued and not yet answered
   logic [PADDR_BITS-1:0] lc_pend[$];
   int                    lc_sel = -1;

   function automatic logic [VALUE_BITS-1:0] rnd_line();
      logic [VALUE_BITS-1:0] v;
      for (int k = 0; k < int'(VALUE_BITS / 32); k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic idle();
      rst_in        = 1'b0;
      req_valid_in  = '0;
      req_we_in     = '0;
      req_addr_in   = '0;
      req_value_in  = '0;
      resp_ready_in = '1;
      lc_ready_in   = 1'b1;
      lc_valid_in   = 1'b0;
      lc_addr_in    = '0;
      lc_value_in   = '0;
      lc_sel        = -1;
   endtask

   // Check one cycle against the model, then advance model and clock
   task automatic step();
      logic [NUM_REQ-1:0] elig, exp_rr, exp_rv;
      logic exp_lcr, can, busy, drain;
      int win, hit;
      #1;
      elig = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         busy = 1'b0;
         foreach (m_trk[k]) if (m_trk[k].line == req_addr_in[i][PADDR_BITS-1:OFF]) busy = 1'b1;
         elig[i] = req_valid_in[i] && (req_we_in[i] || (m_trk.size() < int'(OUTSTANDING) && !busy));
      end
      win = -1;
`ifdef LC_ARB_FIXED_PRIO_EN
      for (int i = 0; i < int'(NUM_REQ); i++) if (elig[i] && win < 0) win = i;
`else
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         int j;
         j = (m_ptr + k) % int'(NUM_REQ);
         if (elig[j] && win < 0) win = j;
      end
`endif
      can = !m_blank && (!m_rq_full || lc_ready_in);
      exp_rr = '0;
      if (can && win >= 0) exp_rr[win] = 1'b1;
      exp_lcr = !m_blank && (!m_rs_full || resp_ready_in[m_rs_owner]);
      exp_rv = '0;
      if (m_rs_full) exp_rv[m_rs_owner] = 1'b1;

      if (m_known) begin
         chk("req_ready", req_ready_out, exp_rr);
         chk("lc_valid", lc_valid_out, m_rq_full);
         if (m_rq_full || m_blank) begin
            chk("lc_addr", lc_addr_out, m_rq_addr);
            chk("lc_value", lc_value_out, m_rq_val);
            chk("lc_we", lc_we_out, m_rq_we);
         end
         chk("lc_ready", lc_ready_out, exp_lcr);
         chk("resp_valid", resp_valid_out, exp_rv);
         if (m_rs_full || m_blank) begin
            chk("resp_addr", resp_addr_out, m_rs_addr);
            chk("resp_value", resp_value_out, m_rs_val);
         end
         chk("err", err_out, m_err);
      end

      // What the lower cache sees, regardless of reset
      if (m_rq_full && lc_ready_in && !m_rq_we) lc_pend.push_back(m_rq_addr);
      if (lc_valid_in && exp_lcr && lc_sel >= 0) lc_pend.delete(lc_sel);

      if (rst_in) begin
         m_known = 1; m_blank = 1; m_ptr = 0;
         m_rq_full = 0; m_rq_addr = '0; m_rq_val = '0; m_rq_we = 0;
         m_trk.delete();
         m_rs_full = 0; m_rs_owner = 0; m_rs_addr = '0; m_rs_val = '0;
         m_err = 0;
      end else begin
         m_blank = 0;
         drain = m_rs_full && resp_ready_in[m_rs_owner];
         if (lc_valid_in && exp_lcr) begin
            hit = -1;
            foreach (m_trk[k]) if (hit < 0 && m_trk[k].line == lc_addr_in[PADDR_BITS-1:OFF]) hit = k;
            if (hit >= 0) begin
               m_rs_full = 1; m_rs_owner = m_trk[hit].owner;
               m_rs_addr = lc_addr_in; m_rs_val = lc_value_in;
               m_trk.delete(hit);
            end else begin
               m_err = 1;
               if (drain) m_rs_full = 0;
            end
         end else if (drain) begin
            m_rs_full = 0;
         end
         if (exp_rr != '0) begin
            m_rq_full = 1;
            m_rq_addr = {req_addr_in[win][PADDR_BITS-1:OFF], OFF'(0)};
            m_rq_val  = req_value_in[win];
            m_rq_we   = req_we_in[win];
            if (!req_we_in[win]) m_trk.push_back('{line: req_addr_in[win][PADDR_BITS-1:OFF], owner: win});
            m_ptr = (win + 1) % int'(NUM_REQ);
         end else if (m_rq_full && lc_ready_in) begin
            m_rq_full = 0;
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   // Random cycle: small line pool forces same-line and table-full stalls
   task automatic drive_random(input int resp_pct);
      rst_in = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req_valid_in[i] = ($urandom_range(0, 2) != 0);
         req_we_in[i]    = ($urandom_range(0, 3) == 0);
         req_addr_in[i]  = {LINE_BITS'(32'h0100 + $urandom_range(0, 5)), OFF'($urandom_range(0, 63))};
         req_value_in[i] = rnd_line();
         resp_ready_in[i] = ($urandom_range(0, 3) != 0);
      end
      lc_ready_in = ($urandom_range(0, 3) != 0);
      lc_value_in = rnd_line();
      if (lc_pend.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
         lc_sel      = $urandom_range(0, lc_pend.size() - 1);
         lc_valid_in = 1'b1;
         lc_addr_in  = lc_pend[lc_sel] | PADDR_BITS'($urandom_range(0, 63));
      end else if ($urandom_range(0, 999) == 0) begin
         lc_sel      = -1;
         lc_valid_in = 1'b1;
         lc_addr_in  = {LINE_BITS'(32'hF000 + $urandom_range(0, 255)), OFF'(0)};
      end else begin
         lc_sel      = -1;
         lc_valid_in = 1'b0;
         lc_addr_in  = PADDR_BITS'($urandom);
      end
   endtask

   int pct_tab[3] = '{60, 5, 90};

   initial begin
      idle();
      @(negedge clk_in);
      rst_in = 1'b1; step(); step();
      rst_in = 1'b0; step();

      // Single read on port 0 with immediate LC accept
      req_valid_in = 2'b01; req_addr_in[0] = 22'h060300; req_we_in[0] = 1'b0;
      req_value_in[0] = rnd_line();
      step();
      chk("t1_lc_valid", lc_valid_out, 1'b1);
      chk("t1_lc_addr", lc_addr_out, 22'h060300);
      chk("t1_lc_we", lc_we_out, 1'b0);
      idle(); step();
      lc_valid_in = 1'b1; lc_addr_in = 22'h060300; lc_value_in = 512'hDEADBEEF;
      lc_sel = 0; resp_ready_in = '0;
      step();
      chk("t1_resp_valid", resp_valid_out, 2'b01);
      chk("t1_resp_value", resp_value_out, 512'hDEADBEEF);
      idle(); step();

      // Unmatched LC response
      lc_valid_in = 1'b1; lc_addr_in = 22'h008000; lc_value_in = rnd_line();
      step();
      chk("t5_no_resp", resp_valid_out, 2'b00);
      chk("t5_err", err_out, 1'b1);
      idle(); step();
      chk("t5_err_sticky", err_out, 1'b1);

      // Reset while a request is held on the LC channel
      req_valid_in = 2'b01; req_addr_in[0] = 22'h002000; lc_ready_in = 1'b0;
      step();
      req_valid_in = '0; step();
      chk("t6_lc_held", lc_valid_out, 1'b1);
      rst_in = 1'b1; step();
      chk("t6_lc_valid_rst", lc_valid_out, 1'b0);
      chk("t6_err_rst", err_out, 1'b0);
      chk("t6_lc_ready_rst", lc_ready_out, 1'b0);
      idle(); step();
      lc_valid_in = 1'b1; lc_addr_in = 22'h002000; lc_value_in = rnd_line();
      step();
      chk("t6_err_late", err_out, 1'b1);
      idle(); rst_in = 1'b1; step();
      idle(); step();

      foreach (pct_tab[p]) begin
         repeat (2000) begin
            drive_random(pct_tab[p]);
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
